// File: rtl/bus_slave_regs_pkg.sv
// Shared bus constants and types for the bus slave register block.
// Holds the active-low enable levels, the read/write encoding, the word
// data type, the responder state encoding and the index of the
// read-only access counter register.
package bus_slave_regs_pkg;

  // Active-low enable levels used by cs_, as_ and rdy_
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Direction encoding carried on rw
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Word data bus
  localparam int WORD_DATA_W = 32;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

  // Register file geometry: eight word registers selected by addr[2:0]
  localparam int REG_NUM   = 8;
  localparam int REG_IDX_W = 3;

  // r7 counts completed accesses and ignores writes
  localparam logic [REG_IDX_W-1:0] BUS_SLV_REG_CNT = 3'h7;

  // Wait counter width; WAIT_CYCLES must fit (0..15)
  localparam int WAIT_CNT_W = 4;

  // Responder state machine encoding
  typedef enum logic [1:0] {
    BUS_SLV_IDLE = 2'h0,
    BUS_SLV_WAIT = 2'h1,
    BUS_SLV_RESP = 2'h2
  } bus_slv_state_t;

  // A bus request is present only when chip select and address strobe
  // are both asserted in the same cycle.
  function automatic logic bus_request(input logic cs_n, input logic as_n);
    return (cs_n == ENABLE_) && (as_n == ENABLE_);
  endfunction

endpackage

// File: rtl/bus_slave_regs.sv
// Bus slave responder with eight 32-bit word registers.
// Captures a request when the decoded chip select and the master's address
// strobe are both low, waits WAIT_CYCLES cycles, then answers with a
// one-cycle active-low ready pulse. r0..r6 are scratch/mailbox registers,
// r7 is a read-only count of completed accesses.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   cs_       chip select from the address decoder, active low
//   as_       address strobe from the bus master, active low
//   addr      register select 0..7
//   rw        1 = read, 0 = write
//   wr_data   write data
//   rd_data   read data, nonzero only during the ready pulse of a read
//   rdy_      ready, active low, one cycle per completed access
//   ctrl_out  live contents of r0
module bus_slave_regs
  import bus_slave_regs_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_,
  input  logic                 as_,
  input  logic [REG_IDX_W-1:0] addr,
  input  logic                 rw,
  input  word_data_t           wr_data,
  output word_data_t           rd_data,
  output logic                 rdy_,
  output word_data_t           ctrl_out
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  bus_slv_state_t         state;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic [REG_IDX_W-1:0]   lat_addr;
  logic                   lat_rw;
  word_data_t             lat_wr_data;
  word_data_t             regs [REG_NUM];

  // r0 is exported as-is for sideband control
  assign ctrl_out = regs[0];

  // Single responder process: request capture, wait-state counting,
  // registered ready/read-data generation and the register file update.
  // rdy_ and rd_data default back to idle every cycle so they can only be
  // active for the one cycle spent in RESP. The read value is loaded on
  // the edge entering RESP, so an r7 read sees the count before this
  // access is added.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BUS_SLV_IDLE;
      wait_cnt    <= '0;
      lat_addr    <= '0;
      lat_rw      <= WRITE;
      lat_wr_data <= '0;
      rdy_        <= DISABLE_;
      rd_data     <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else begin
      rdy_    <= DISABLE_;
      rd_data <= '0;
      case (state)
        BUS_SLV_IDLE: begin
          if (bus_request(cs_, as_)) begin
            lat_addr    <= addr;
            lat_rw      <= rw;
            lat_wr_data <= wr_data;
            wait_cnt    <= WAIT_LOAD;
            if (WAIT_LOAD == '0) begin
              // Zero wait states: the capture edge is also the edge that
              // enters RESP, so use the live inputs for the read mux.
              state <= BUS_SLV_RESP;
              rdy_  <= ENABLE_;
              if (rw == READ) begin
                rd_data <= regs[addr];
              end
            end else begin
              state <= BUS_SLV_WAIT;
            end
          end
        end

        BUS_SLV_WAIT: begin
          if (!bus_request(cs_, as_)) begin
            // Master withdrew the request: drop it without side effects
            state    <= BUS_SLV_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_CNT_W'(1)) begin
            wait_cnt <= '0;
            state    <= BUS_SLV_RESP;
            rdy_     <= ENABLE_;
            if (lat_rw == READ) begin
              rd_data <= regs[lat_addr];
            end
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end

        BUS_SLV_RESP: begin
          if ((lat_rw == WRITE) && (lat_addr != BUS_SLV_REG_CNT)) begin
            regs[lat_addr] <= lat_wr_data;
          end
          regs[BUS_SLV_REG_CNT] <= regs[BUS_SLV_REG_CNT] + 32'd1;
          state <= BUS_SLV_IDLE;
        end

        default: begin
          state <= BUS_SLV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_slave_regs.md
# bus_slave_regs

Bus slave responder with eight 32-bit word registers, serving the other end of the shared bus from the address decoder: it consumes a decoded active-low chip select plus the master's address strobe, inserts a programmable number of wait states, and returns read data with an active-low ready pulse. It sits on any free slave slot (`s0_cs_`..`s7_cs_`) and serves as a scratch/mailbox register block and as the reference responder for bus timing verification.

## Interface
- `WAIT_CYCLES`, default 2: wait states inserted between request capture and ready; legal range 0..15.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `cs_`  input  1  chip select from address decoder, active low.
- `as_`  input  1  address strobe from bus master, active low.
- `addr`  input  3  word address bits [2:0] of `WordAddrBus`; selects register 0..7.
- `rw`  input  1  `READ` (1) or `WRITE` (0).
- `wr_data`  input  32  write data (`WordDataBus`).
- `rd_data`  output  32  read data; valid only while `rdy_` is `ENABLE_`, else 0.
- `rdy_`  output  1  ready, active low; one-cycle pulse ending the access.
- `ctrl_out`  output  32  live contents of register 0, for sideband control use.

## Operation
- Registers: r0..r6 read/write; r7 read-only access counter (completed accesses, reads and writes), wraps 0xFFFF_FFFF -> 0. Writes to r7 are completed normally (`rdy_` pulsed) but discarded.
- State machine: IDLE, WAIT, RESP.
  - IDLE: when `cs_`==0 and `as_`==0, latch `addr`, `rw`, `wr_data`; load wait counter with `WAIT_CYCLES`; go WAIT if `WAIT_CYCLES`>0, else RESP.
  - WAIT: decrement counter; on reaching 0 go RESP. If `cs_` or `as_` goes high (abort), return to IDLE, no write, no counter increment, no `rdy_`.
  - RESP: drive `rdy_`=0 for exactly this cycle; for read, drive `rd_data` = latched register; for write, commit latched `wr_data` at end of this cycle; increment r7; go IDLE unconditionally.
- Inputs are sampled only at capture in IDLE; changes to `addr`/`wr_data`/`rw` during WAIT are ignored.
- Read of r7 in RESP returns the count before this access's increment.
- Read-after-write to the same register in back-to-back accesses returns the new value.
- `cs_`==0 with `as_`==1 (or vice versa) is ignored in IDLE.

## Timing
- Reset values: state IDLE, `rdy_`=1, `rd_data`=0, r0..r7=0, `ctrl_out`=0, wait counter 0.
- Reset asserted mid-access: next cycle in IDLE with reset values; pending write lost.
- Latency: request sampled on edge N -> `rdy_` low during cycle N+1+`WAIT_CYCLES`, registered output (no combinational path input->`rdy_`/`rd_data`).
- `ctrl_out` reflects a write to r0 the cycle after RESP.
- Master holding `as_` low after `rdy_` starts a new access: IDLE recaptures on the cycle after RESP; minimum access spacing `WAIT_CYCLES`+2 cycles.

## Structure
- Constants from the shared `bus.h`/`stddef.h` headers: `ENABLE_`/`DISABLE_`, `READ`/`WRITE`, `WordDataBus`, `WordAddrBus`; state encodings (`BUS_SLV_IDLE`, `BUS_SLV_WAIT`, `BUS_SLV_RESP`, 2 bits) and register index `BUS_SLV_REG_CNT` (3'h7) added to `bus.h`.
- Single module; no sub-module needed.

## Test plan
- Reset, then idle 5 cycles -> `rdy_`=1, `rd_data`=0, `ctrl_out`=0 throughout.
- `WAIT_CYCLES`=2: write 0xDEAD_BEEF to r3 sampled edge 10 -> `rdy_` low only in cycle 13; read r3 -> `rd_data`=0xDEAD_BEEF with `rdy_` low, 0 otherwise.
- Write 0x0000_00A5 to r0 -> `ctrl_out`=0x0000_00A5 the cycle after RESP; write 0x1234 to r7 -> `rdy_` pulses, r7 read returns access count (2), not 0x1234.
- Abort: start write to r1, release `as_` one cycle into WAIT -> no `rdy_`, r1 stays 0, r7 unchanged.
- `WAIT_CYCLES`=0, `as_` held low for 3 back-to-back reads of r7 -> `rdy_` every 2nd cycle, values 0,1,2.
- Assert `reset` during WAIT of a write to r2 -> `rdy_` never pulses, r2=0, r7=0, state IDLE.
